// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 iterative inverse cipher.
//   INV_SBOX         : 256-entry AES inverse S-box
//   aes_state_t      : 128-bit cipher state, bit 127 is byte 0, column-major
//   AES256_ROUNDS    : number of AES-256 rounds (14)
//   AES_KEY_CHAIN_W  : width of the expanded key chain (1920)
//   aes_dec_state_e  : decrypt FSM states IDLE / ROUND / DONE
//   xtime / gmul     : GF(2^8) helpers over polynomial 0x11B, no multipliers
package aes_pkg;

  localparam int AES256_ROUNDS   = 14;
  localparam int AES_KEY_CHAIN_W = 128 * (AES256_ROUNDS + 1);

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_dec_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8), reducing by 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant (9, b, d, e for InvMixColumns) as an XOR of
  // the xtime chain b, 2b, 4b, 8b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round:
//   result = InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), round_key))
// with InvMixColumns bypassed when last_round is set.
// Ports:
//   state      in  128  current cipher state (bit 127 = byte 0, column-major)
//   round_key  in  128  round key for this round
//   last_round in  1    skip InvMixColumns
//   result     out 128  next state
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  output logic [127:0] result
);

  logic [7:0] ark [16];
  logic [7:0] mix [16];

  // Byte gi sits at row gi%4, column gi/4. InvShiftRows rotates row r right
  // by r, so output (r,c) takes input (r,(c-r) mod 4).
  for (genvar gi = 0; gi < 16; gi++) begin : g_byte
    localparam int ROW = gi % 4;
    localparam int COL = gi / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    assign ark[gi] = INV_SBOX[state[127-8*SRC -: 8]] ^ round_key[127-8*gi -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[4*gi+0];
    assign a1 = ark[4*gi+1];
    assign a2 = ark[4*gi+2];
    assign a3 = ark[4*gi+3];
    assign mix[4*gi+0] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
    assign mix[4*gi+1] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
    assign mix[4*gi+2] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
    assign mix[4*gi+3] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_out
    assign result[127-8*gi -: 8] = last_round ? ark[gi] : mix[gi];
  end

endmodule

// File: rtl/aes256_iter_decrypt.sv
// Iterative AES-256 inverse cipher, one round per clock.
// A job is accepted on v_i & ready_o, runs 14 round cycles and then presents
// the plaintext on v_o until the consumer asserts yumi_i.
// Ports:
//   clk_i        in  1     clock
//   reset_i      in  1     synchronous active-high reset, aborts any job
//   v_i          in  1     ciphertext/key chain valid
//   ready_o      out 1     idle, can accept a job
//   ciphertext_i in  128   ciphertext block (bit 127 = byte 0)
//   key_chain_i  in  1920  round key r at [128*r +: 128]
//   v_o          out 1     plaintext_o valid
//   plaintext_o  out 128   decrypted block (zero when not valid)
//   yumi_i       in  1     consumer takes plaintext_o (only while v_o)
// Build option AES_DEC_KEY_LATCH_EN: latch key_chain_i at accept so the
// source may change it afterwards; otherwise it must be held until yumi_i.
module aes256_iter_decrypt
  import aes_pkg::*;
#(
  parameter int rounds_p          = AES256_ROUNDS,
  parameter int key_chain_width_p = 128 * (rounds_p + 1)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  output logic                         ready_o,
  input  logic [127:0]                 ciphertext_i,
  input  logic [key_chain_width_p-1:0] key_chain_i,
  output logic                         v_o,
  output logic [127:0]                 plaintext_o,
  input  logic                         yumi_i
);

  if (rounds_p != AES256_ROUNDS || key_chain_width_p != AES_KEY_CHAIN_W) begin : g_bad_cfg
    $error("aes256_iter_decrypt supports only 14 rounds with a 1920-bit key chain");
  end

  aes_dec_state_e fsm_reg, fsm_next;
  logic [127:0]   data_reg, data_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [127:0]   round_key;
  logic [127:0]   round_out;
  logic           accept;

`ifdef AES_DEC_KEY_LATCH_EN
  logic [key_chain_width_p-1:0] key_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      key_reg <= '0;
    end else if (accept) begin
      key_reg <= key_chain_i;
    end
  end

  assign round_key = key_reg[{cnt_reg, 7'b0} +: 128];
`else
  assign round_key = key_chain_i[{cnt_reg, 7'b0} +: 128];
`endif

  aes_inv_round u_round (
    .state      (data_reg),
    .round_key  (round_key),
    .last_round (cnt_reg == 4'd0),
    .result     (round_out)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_reg  <= IDLE;
      data_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      fsm_reg  <= fsm_next;
      data_reg <= data_next;
      cnt_reg  <= cnt_next;
    end
  end

  always_comb begin
    fsm_next    = fsm_reg;
    data_next   = data_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    ready_o     = 1'b0;
    v_o         = 1'b0;
    plaintext_o = '0;
    case (fsm_reg)
      IDLE: begin
        ready_o = 1'b1;
        if (v_i) begin
          // The initial AddRoundKey always uses the live input: the latched
          // copy (if any) only becomes valid on the following edge.
          accept    = 1'b1;
          data_next = ciphertext_i ^ key_chain_i[128*rounds_p +: 128];
          cnt_next  = 4'(rounds_p - 1);
          fsm_next  = ROUND;
        end
      end
      ROUND: begin
        data_next = round_out;
        if (cnt_reg == 4'd0) begin
          fsm_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE: begin
        v_o         = 1'b1;
        plaintext_o = data_reg;
        if (yumi_i) begin
          fsm_next = IDLE;
        end
      end
      default: fsm_next = IDLE;
    endcase
  end

  // yumi_i is only meaningful while a result is being offered.
  yumi_only_in_done: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> (fsm_reg == DONE));

endmodule

// File: tb/tb_aes256_iter_decrypt.sv
// Scoreboard bench for aes256_iter_decrypt. The reference model is a plain
// AES-256 key expansion and forward cipher; each job's expected output is
// the plaintext that was encrypted to form its ciphertext.
module tb_aes256_iter_decrypt;

  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic          ready_o;
  logic [127:0]  ciphertext_i;
  logic [1919:0] key_chain_i;
  logic          v_o;
  logic [127:0]  plaintext_o;
  logic          yumi_i;
  logic          yumi_auto;
  logic          yumi_man;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int txn    = 0;

  logic [7:0]    sbox_t [256];
  logic [127:0]  exp_q [$];
  int            t_q [$];
  logic [1919:0] c3_chain;

  assign yumi_i = yumi_auto ? v_o : yumi_man;

  always #5 clk = ~clk;

  aes256_iter_decrypt dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .ready_o      (ready_o),
    .ciphertext_i (ciphertext_i),
    .key_chain_i  (key_chain_i),
    .v_o          (v_o),
    .plaintext_o  (plaintext_o),
    .yumi_i       (yumi_i)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gf_mul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [1919:0] expand_key(input logic [255:0] key);
    logic [31:0]   w [60];
    logic [31:0]   tmp;
    logic [7:0]    rc;
    logic [1919:0] chain;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gf_mul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) chain[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return chain;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1919:0] chain);
    logic [127:0] st;
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    st = pt ^ chain[127:0];
    for (int r = 1; r <= 14; r++) begin
      for (int i = 0; i < 16; i++) b[i] = sbox_t[st[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
      if (r != 14) begin
        for (int c = 0; c < 4; c++) begin
          for (int rr = 0; rr < 4; rr++) a[rr] = t[4*c+rr];
          for (int rr = 0; rr < 4; rr++)
            t[4*c+rr] = gf_mul(a[rr], 8'h02) ^ gf_mul(a[(rr+1)%4], 8'h03) ^ a[(rr+2)%4] ^ a[(rr+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = t[i];
      st = st ^ chain[128*r +: 128];
    end
    return st;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [127:0] ct, input logic [1919:0] chain, input logic [127:0] pt, output int t);
    int budget;
    budget = 0;
    t = -1;
    while (!ready_o && budget < 100) begin
      tick();
      budget++;
    end
    if (!ready_o) begin
      timeout("send_ready");
      return;
    end
    ciphertext_i = ct;
    key_chain_i  = chain;
    v_i          = 1'b1;
    t            = cyc;
    exp_q.push_back(pt);
    t_q.push_back(cyc);
    tick();
    v_i = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      tick();
      budget++;
    end
    if (exp_q.size() != 0) begin
      timeout("drain");
      exp_q.delete();
      t_q.delete();
    end
  endtask

  // ---------------- cycle counter ----------------
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic         v_prev;
    int           t;
    logic [127:0] e;
    v_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        v_prev = 1'b0;
      end else begin
        if (v_o && !v_prev) begin
          if (t_q.size() == 0) begin
            timeout("unexpected_v_o");
          end else begin
            t = t_q.pop_front();
            check("latency", 128'(cyc), 128'(t + 15));
          end
        end
        if (v_o && yumi_i) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_result");
          end else begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d cycle %0d plaintext=%h expected=%h", txn, cyc, plaintext_o, e);
            check("plaintext", plaintext_o, e);
          end
        end
        v_prev = v_o;
      end
    end
  end

`ifndef AES_DEC_KEY_LATCH_EN
  // Without the key latch, key_chain_i must not move while a job is in flight.
  initial begin
    logic          key_hold;
    logic [1919:0] key_snap;
    key_hold = 1'b0;
    key_snap = '0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        key_hold = 1'b0;
      end else begin
        if (key_hold) begin
          checks++;
          key_stable: assert (key_chain_i == key_snap) else begin
            errors++;
            $display("FAIL key_stable: key_chain_i changed while a job was in flight (cycle %0d)", cyc);
          end
        end
        if (v_i && ready_o) begin
          key_hold = 1'b1;
          key_snap = key_chain_i;
        end
        if (v_o && yumi_i) key_hold = 1'b0;
      end
    end
  end
`endif

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0]  pt, ct;
    logic [255:0]  key;
    logic [1919:0] chain;
    int            t_now, t_prev, budget;

    reset_i      = 1'b1;
    v_i          = 1'b0;
    yumi_auto    = 1'b0;
    yumi_man     = 1'b0;
    ciphertext_i = '0;
    key_chain_i  = '0;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    c3_chain = expand_key(C3_KEY);

    // Reset values
    repeat (3) tick();
    check("reset_ready", 128'(ready_o), 128'(1));
    check("reset_v_o", 128'(v_o), 128'(0));
    check("reset_plaintext", plaintext_o, 128'(0));
    reset_i = 1'b0;
    tick();

    // Known-answer vector
    yumi_auto = 1'b1;
    send(C3_CT, c3_chain, C3_PT, t_now);
    drain();

    // Random loopback, back-to-back
    t_prev = 0;
    for (int j = 0; j < 200; j++) begin
      for (int w = 0; w < 4; w++) pt[32*w +: 32] = $urandom();
      for (int w = 0; w < 8; w++) key[32*w +: 32] = $urandom();
      chain = expand_key(key);
      ct    = encrypt(pt, chain);
      send(ct, chain, pt, t_now);
      if (j > 0) check("spacing", 128'(t_now - t_prev), 128'(16));
      t_prev = t_now;
    end
    drain();

    // Backpressure: result held while yumi_i stays low, new v_i ignored
    yumi_auto = 1'b0;
    send(C3_CT, c3_chain, C3_PT, t_now);
    budget = 0;
    while (!v_o && budget < 30) begin
      tick();
      budget++;
    end
    if (!v_o) timeout("backpressure_v_o");
    for (int k = 0; k < 50; k++) begin
      ciphertext_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      v_i          = 1'b1;
      check("bp_v_o", 128'(v_o), 128'(1));
      check("bp_plaintext", plaintext_o, C3_PT);
      check("bp_ready", 128'(ready_o), 128'(0));
      tick();
    end
    v_i      = 1'b0;
    yumi_man = 1'b1;
    tick();
    yumi_man = 1'b0;
    check("after_yumi_ready", 128'(ready_o), 128'(1));
    check("after_yumi_v_o", 128'(v_o), 128'(0));
    check("after_yumi_queue", 128'(exp_q.size()), 128'(0));

    // Reset in the middle of the rounds
    yumi_auto = 1'b1;
    send(C3_CT, c3_chain, C3_PT, t_now);
    repeat (6) tick();
    check("mid_round_v_o", 128'(v_o), 128'(0));
    reset_i = 1'b1;
    exp_q.delete();
    t_q.delete();
    tick();
    reset_i = 1'b0;
    check("abort_v_o", 128'(v_o), 128'(0));
    check("abort_plaintext", plaintext_o, 128'(0));
    check("abort_ready", 128'(ready_o), 128'(1));
    send(C3_CT, c3_chain, C3_PT, t_now);
    drain();

`ifdef AES_DEC_KEY_LATCH_EN
    // Key chain scrambled from the cycle after acceptance
    send(C3_CT, c3_chain, C3_PT, t_now);
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      for (int w = 0; w < 60; w++) key_chain_i[32*w +: 32] = $urandom();
      tick();
      budget++;
    end
    if (exp_q.size() != 0) timeout("latch_drain");
    key_chain_i = c3_chain;
`endif

    repeat (3) tick();
    check("final_queue", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
